bt_cmd_parser: RTL and testbench

BT_CMD_PARSER -- requirements
Module: bt_cmd_parser

---
 rtl/bt_cmd_parser.sv | 187 ++++++++++++++++++
 tb/tb_bt_cmd_parser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_parser.sv
// ============================================================================
//  Module      : bt_cmd_parser
//  Description : UART byte-stream command frame parser
//                (HEADER, CMD, LEN, DATA[LEN], XOR checksum) with timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bt_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  RxData,
    input  logic        RxDone,
    output logic        CmdValid,
    output logic [7:0]  Cmd,
    output logic [31:0] Payload,
    output logic [2:0]  PayLen,
    output logic        FrameErr,
    output logic [1:0]  ErrCode,
    output logic        Busy
);

    localparam int               c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       c_MAX_LEN  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4
    } t_state;

    t_state              r_state, w_state_nxt;
    logic                r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]          r_prime;
    logic                r_armed;
    logic                r_strobe;
    logic [7:0]          r_byte;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [7:0]          r_cmd, w_cmd_nxt;
    logic [7:0]          r_csum, w_csum_nxt;
    logic [31:0]         r_pay, w_pay_nxt;
    logic [2:0]          r_len, w_len_nxt;
    logic [1:0]          r_idx, w_idx_nxt;
    logic                w_ok, w_err;
    logic [1:0]          w_err_code;
    logic                w_timeout;

    // The edge detector only arms after the synchronizer has seen RxDone low,
    // so a level already high at reset release cannot masquerade as a byte.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_prev <= 1'b0;
            r_prime   <= 2'b00;
            r_armed   <= 1'b0;
            r_strobe  <= 1'b0;
            r_byte    <= 8'h00;
        end else begin
            r_rx_meta <= RxDone;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_prime   <= {r_prime[0], 1'b1};
            r_armed   <= r_armed | (r_prime[1] & ~r_rx_sync);
            r_strobe  <= r_rx_sync & ~r_rx_prev & r_armed;
            if (r_rx_sync && !r_rx_prev && r_armed) begin
                r_byte <= RxData;
            end
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !r_strobe && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_IDLE || r_strobe) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != c_TMO_LAST) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_csum_nxt  = r_csum;
        w_pay_nxt   = r_pay;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ErrCode;
        if (r_strobe) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == HEADER) w_state_nxt = S_CMD;
                end
                S_CMD: begin
                    w_cmd_nxt   = r_byte;
                    w_csum_nxt  = r_byte;
                    w_pay_nxt   = 32'h0;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_LEN;
                end
                S_LEN: begin
                    w_csum_nxt = r_csum ^ r_byte;
                    if (r_byte == 8'h00) begin
                        w_len_nxt   = 3'd0;
                        w_state_nxt = S_CSUM;
                    end else if (r_byte > c_MAX_LEN) begin
                        w_err       = 1'b1;
                        w_err_code  = 2'd2;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_len_nxt   = r_byte[2:0];
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_csum_nxt             = r_csum ^ r_byte;
                    w_pay_nxt[8*r_idx +: 8] = r_byte;
                    w_idx_nxt              = r_idx + 2'd1;
                    if ({1'b0, r_idx} == r_len - 3'd1) w_state_nxt = S_CSUM;
                end
                S_CSUM: begin
                    if (r_byte == r_csum) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 2'd1;
                    end
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_err       = 1'b1;
            w_err_code  = 2'd3;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_cmd    <= 8'h00;
            r_csum   <= 8'h00;
            r_pay    <= 32'h0;
            r_len    <= 3'd0;
            r_idx    <= 2'd0;
            CmdValid <= 1'b0;
            FrameErr <= 1'b0;
            ErrCode  <= 2'd0;
            Cmd      <= 8'h00;
            Payload  <= 32'h0;
            PayLen   <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cmd    <= w_cmd_nxt;
            r_csum   <= w_csum_nxt;
            r_pay    <= w_pay_nxt;
            r_len    <= w_len_nxt;
            r_idx    <= w_idx_nxt;
            CmdValid <= w_ok;
            FrameErr <= w_err;
            ErrCode  <= w_err_code;
            if (w_ok) begin
                Cmd     <= r_cmd;
                Payload <= r_pay;
                PayLen  <= r_len;
            end
        end
    end

    assign Busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bt_cmd_parser.sv
// ============================================================================
//  Module      : tb_bt_cmd_parser
//  Description : Directed self-checking bench for bt_cmd_parser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bt_cmd_parser;

    localparam int c_T  = 100;
    localparam int c_NV = 7;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxDone = 1'b0;
    logic        CmdValid, FrameErr, Busy;
    logic [7:0]  Cmd;
    logic [31:0] Payload;
    logic [2:0]  PayLen;
    logic [1:0]  ErrCode;

    bt_cmd_parser #(.HEADER(8'hAA), .MAX_LEN(4), .TIMEOUT_CYC(c_T)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .RxData(RxData), .RxDone(RxDone),
        .CmdValid(CmdValid), .Cmd(Cmd), .Payload(Payload), .PayLen(PayLen),
        .FrameErr(FrameErr), .ErrCode(ErrCode), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_both = 0, valid_cyc = 0;
    int last_raise = 0;
    int v0, e0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (CmdValid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (FrameErr) n_err++;
        if (CmdValid && FrameErr) n_both++;
    end

    typedef struct {
        logic [63:0] bytes;   // first byte sent in [63:56]
        int          n;
        int          dv;
        int          de;
        logic [7:0]  cmd;
        logic [31:0] pay;
        logic [2:0]  len;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [c_NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge Clk);
        RxData     = b;
        RxDone     = 1'b1;
        last_raise = cyc;
        repeat (hold) @(negedge Clk);
        RxDone = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c, input logic [31:0] p,
                           input logic [2:0] l);
        chk({tag, ".cmd"}, {24'h0, Cmd}, {24'h0, c});
        chk({tag, ".payload"}, Payload, p);
        chk({tag, ".paylen"}, {29'h0, PayLen}, {29'h0, l});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hAA10023456700000, 6, 1, 0, 8'h10, 32'h00005634, 3'd2, 2'd0};
        vecs[1] = '{64'hAA10023456710000, 6, 0, 1, 8'h10, 32'h00005634, 3'd2, 2'd1};
        vecs[2] = '{64'hAA05050000000000, 3, 0, 1, 8'h10, 32'h00005634, 3'd2, 2'd2};
        vecs[3] = '{64'hAA07000700000000, 4, 1, 0, 8'h07, 32'h00000000, 3'd0, 2'd2};
        // Checksum of 01 01 AA is AA, so AB must be rejected.
        vecs[4] = '{64'h00FF55AA0101AAAB, 8, 0, 1, 8'h07, 32'h00000000, 3'd0, 2'd1};
        vecs[5] = '{64'hAA0101AAAA000000, 5, 1, 0, 8'h01, 32'h000000AA, 3'd1, 2'd1};
        vecs[6] = '{64'hAA22041122334462, 8, 1, 0, 8'h22, 32'h44332211, 3'd4, 2'd1};

        repeat (3) @(negedge Clk);
        chk("rst.valid", {31'h0, CmdValid}, 32'h0);
        chk("rst.err", {31'h0, FrameErr}, 32'h0);
        chk("rst.code", {30'h0, ErrCode}, 32'h0);
        chk("rst.busy", {31'h0, Busy}, 32'h0);
        chk_out("rst", 8'h00, 32'h0, 3'd0);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);

        for (int i = 0; i < c_NV; i++) begin
            v0 = n_valid;
            e0 = n_err;
            for (int k = 0; k < vecs[i].n; k++) send(vecs[i].bytes[63-8*k -: 8], 3);
            repeat (4) @(negedge Clk);
            chk($sformatf("vec%0d.nvalid", i), 32'(n_valid - v0), 32'(vecs[i].dv));
            chk($sformatf("vec%0d.nerr", i), 32'(n_err - e0), 32'(vecs[i].de));
            chk($sformatf("vec%0d.code", i), {30'h0, ErrCode}, {30'h0, vecs[i].code});
            chk_out($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].pay, vecs[i].len);
            chk($sformatf("vec%0d.busy", i), {31'h0, Busy}, 32'h0);
        end

        // Timeout after AA 10, then Busy must drop.
        v0 = n_valid; e0 = n_err;
        send(8'hAA, 3); send(8'h10, 3);
        chk("tmo.busy_before", {31'h0, Busy}, 32'h1);
        repeat (150) @(negedge Clk);
        chk("tmo.nerr", 32'(n_err - e0), 32'd1);
        chk("tmo.code", {30'h0, ErrCode}, 32'd3);
        chk("tmo.busy_after", {31'h0, Busy}, 32'h0);
        chk("tmo.nvalid", 32'(n_valid - v0), 32'd0);

        // Byte strobe exactly on the terminal count: no timeout.
        v0 = n_valid; e0 = n_err;
        send(8'hAA, 3); send(8'h10, 3); send(8'h02, 3); send(8'h34, 3);
        repeat (c_T - 8) @(negedge Clk);
        send(8'h56, 3); send(8'h70, 3);
        chk("edge.latency", 32'(valid_cyc - last_raise), 32'd4);
        repeat (4) @(negedge Clk);
        chk("edge.nvalid", 32'(n_valid - v0), 32'd1);
        chk("edge.nerr", 32'(n_err - e0), 32'd0);
        chk_out("edge", 8'h10, 32'h00005634, 3'd2);

        // One cycle later the timeout fires and trailing bytes are discarded.
        v0 = n_valid; e0 = n_err;
        send(8'hAA, 3); send(8'h20, 3); send(8'h02, 3); send(8'h34, 3);
        repeat (c_T - 7) @(negedge Clk);
        send(8'h56, 3); send(8'h40, 3);
        repeat (4) @(negedge Clk);
        chk("late.nerr", 32'(n_err - e0), 32'd1);
        chk("late.code", {30'h0, ErrCode}, 32'd3);
        chk("late.nvalid", 32'(n_valid - v0), 32'd0);
        chk_out("late", 8'h10, 32'h00005634, 3'd2);

        // RxDone held high 40 cycles yields a single strobe.
        v0 = n_valid; e0 = n_err;
        send(8'hAA, 40);
        send(8'h33, 3); send(8'h01, 3); send(8'h5A, 3); send(8'h68, 3);
        repeat (4) @(negedge Clk);
        chk("hold.nvalid", 32'(n_valid - v0), 32'd1);
        chk("hold.nerr", 32'(n_err - e0), 32'd0);
        chk_out("hold", 8'h33, 32'h0000005A, 3'd1);

        // Reset mid-frame forces reset values immediately.
        send(8'hAA, 3); send(8'h10, 3); send(8'h02, 3); send(8'h34, 3);
        #2 Rst_n = 1'b0;
        #1;
        chk("mrst.valid", {31'h0, CmdValid}, 32'h0);
        chk("mrst.err", {31'h0, FrameErr}, 32'h0);
        chk("mrst.code", {30'h0, ErrCode}, 32'h0);
        chk("mrst.busy", {31'h0, Busy}, 32'h0);
        chk_out("mrst", 8'h00, 32'h0, 3'd0);
        // RxDone already high at release must not produce a strobe.
        RxData = 8'hAA;
        RxDone = 1'b1;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        chk("rel.busy_high", {31'h0, Busy}, 32'h0);
        RxDone = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rel.busy", {31'h0, Busy}, 32'h0);

        v0 = n_valid; e0 = n_err;
        send(8'hAA, 3); send(8'h10, 3); send(8'h02, 3);
        send(8'h34, 3); send(8'h56, 3); send(8'h70, 3);
        repeat (4) @(negedge Clk);
        chk("post.nvalid", 32'(n_valid - v0), 32'd1);
        chk("post.nerr", 32'(n_err - e0), 32'd0);
        chk("post.code", {30'h0, ErrCode}, 32'h0);
        chk_out("post", 8'h10, 32'h00005634, 3'd2);

        chk("exclusive", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
